// File: rtl/l1a_chk_pkg.sv
// Shared types and helpers for the L1A alignment checker: FSM state encoding,
// parameter defaults and the per-channel slice extractor for the packed L1A bus.
package l1a_chk_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CAPTURE_REF = 2'd1,
    COMPARE     = 2'd2,
    DONE        = 2'd3
  } l1a_chk_state_e;

  localparam int              DEF_N_CH    = 16;
  localparam int              DEF_L1A_W   = 14;
  localparam logic [15:0]     DEF_TMO_CYC = 16'd4000;

  // Upper bounds used to size the generic slice helper.
  localparam int MAX_N_CH  = 32;
  localparam int MAX_L1A_W = 32;
  localparam int VEC_W     = MAX_N_CH * MAX_L1A_W;

  // Returns channel k (width w) of a packed vector; bits above w read as zero.
  function automatic logic [MAX_L1A_W-1:0] l1a_of_ch(
    input logic [VEC_W-1:0] vec,
    input int unsigned      k,
    input int unsigned      w
  );
    logic [VEC_W-1:0]     sh;
    logic [MAX_L1A_W-1:0] r;
    sh = vec >> (k * w);
    r  = '0;
    for (int i = 0; i < MAX_L1A_W; i++) begin
      if (i < int'(w)) r[i] = sh[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1a_chk_prio_enc.sv
// Lowest-set-bit encoder: finds the lowest request at or strictly above a base
// index. Used for both the first enabled channel and the next one to visit.
module l1a_chk_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  input  logic             strict,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan downward so the last hit written is the lowest qualifying bit.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (strict ? (i > int'(base)) : (i >= int'(base)))) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1a_align_checker_n.sv
// L1A alignment checker over N_CH channels: reference from the first enabled
// channel, compare the rest in ascending order. Optional per-channel wait
// timeout is built when L1A_CHK_TIMEOUT_EN is defined.
module l1a_align_checker_n
  import l1a_chk_pkg::*;
#(
  parameter int               N_CH    = DEF_N_CH,
  parameter int               L1A_W   = DEF_L1A_W,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(DEF_TMO_CYC),
  parameter int               CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  check_en,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       trig_in,
  input  logic [N_CH*L1A_W-1:0] l1a_in,
  input  logic                  clr_err,
  output logic                  l1a_align,
  output logic                  round_done,
  output logic                  ch_done,
  output logic [N_CH-1:0]       error,
  output logic [N_CH-1:0]       err_sticky,
  output logic [L1A_W-1:0]      ref_l1a,
  output logic [CNT_W-1:0]      mismatch_cnt,
  output logic                  busy,
  output l1a_chk_state_e        dbg_state
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  l1a_chk_state_e   state_q, state_d;
  logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [L1A_W-1:0] ref_q, ref_d;
  logic [N_CH-1:0]  error_q, error_d;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             round_err_q, round_err_d;
  logic             ch_done_q, ch_done_d;
  logic             round_done_q, round_done_d;
  logic             align_q, align_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] first_idx, next_idx;
  logic             first_valid, next_valid;
  logic [VEC_W-1:0] l1a_ext;
  logic [L1A_W-1:0] cur_l1a;
  logic             trig_sel;
  logic             tmo_hit;

  // First channel follows the live mask (round not started yet); the walk
  // through a running round uses the mask latched at round start.
  l1a_chk_prio_enc #(.N(N_CH), .IDX_W(IDX_W)) u_first_enc (
    .req(ch_en), .base('0), .strict(1'b0), .idx(first_idx), .valid(first_valid)
  );

  l1a_chk_prio_enc #(.N(N_CH), .IDX_W(IDX_W)) u_next_enc (
    .req(mask_q), .base(ch_idx_q), .strict(1'b1), .idx(next_idx), .valid(next_valid)
  );

  assign l1a_ext  = VEC_W'(l1a_in);
  assign cur_l1a  = L1A_W'(l1a_of_ch(l1a_ext, 32'(ch_idx_q), L1A_W));
  assign trig_sel = trig_in[ch_idx_q];

`ifdef L1A_CHK_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  // Restarts whenever the FSM moves to a new channel or leaves the wait states.
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else if (!busy_d || state_d != state_q || ch_idx_d != ch_idx_q) tmo_q <= '0;
    else tmo_q <= tmo_q + TMO_W'(1);
  end

  assign tmo_hit = busy_q && (tmo_q == TMO_CYC - TMO_W'(1));
`else
  // Unbounded wait: only check_en or reset releases a silent channel.
  localparam bit TMO_CFG = (TMO_W > 0) && (TMO_CYC != '0);
  assign tmo_hit = TMO_CFG & 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    mask_d       = mask_q;
    ref_d        = ref_q;
    error_d      = error_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    round_err_d  = round_err_q;
    ch_done_d    = 1'b0;
    round_done_d = 1'b0;
    align_d      = 1'b0;

    // Clear first so a same-cycle new error overrides it.
    if (clr_err) begin
      sticky_d = '0;
      cnt_d    = '0;
    end

    case (state_q)
      IDLE: begin
        if (check_en && ch_en != '0) begin
          ch_idx_d    = first_idx;
          mask_d      = ch_en;
          round_err_d = 1'b0;
          state_d     = CAPTURE_REF;
        end else if (!check_en && first_valid && trig_in[first_idx]) begin
          error_d[first_idx]  = 1'b1;
          sticky_d[first_idx] = 1'b1;
        end
      end
      CAPTURE_REF, COMPARE: begin
        if (!check_en) begin
          state_d = IDLE;
        end else if (trig_sel || tmo_hit) begin
          ch_done_d = 1'b1;
          if (!trig_sel) begin
            error_d[ch_idx_q]  = 1'b1;
            sticky_d[ch_idx_q] = 1'b1;
            round_err_d        = 1'b1;
          end else if (state_q == CAPTURE_REF) begin
            ref_d             = cur_l1a;
            error_d[ch_idx_q] = 1'b0;
          end else if (cur_l1a == ref_q) begin
            error_d[ch_idx_q] = 1'b0;
          end else begin
            error_d[ch_idx_q]  = 1'b1;
            sticky_d[ch_idx_q] = 1'b1;
            round_err_d        = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
          end
          if (next_valid) begin
            ch_idx_d = next_idx;
            state_d  = COMPARE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        round_done_d = 1'b1;
        align_d      = !round_err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE_REF) || (state_d == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_idx_q     <= '0;
      mask_q       <= '0;
      ref_q        <= '0;
      error_q      <= '0;
      sticky_q     <= '0;
      cnt_q        <= '0;
      round_err_q  <= 1'b0;
      ch_done_q    <= 1'b0;
      round_done_q <= 1'b0;
      align_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      mask_q       <= mask_d;
      ref_q        <= ref_d;
      error_q      <= error_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
      round_err_q  <= round_err_d;
      ch_done_q    <= ch_done_d;
      round_done_q <= round_done_d;
      align_q      <= align_d;
      busy_q       <= busy_d;
    end
  end

  assign l1a_align    = align_q;
  assign round_done   = round_done_q;
  assign ch_done      = ch_done_q;
  assign error        = error_q;
  assign err_sticky   = sticky_q;
  assign ref_l1a      = ref_q;
  assign mismatch_cnt = cnt_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_l1a_align_checker_n.sv
// Directed bench for l1a_align_checker_n (4 channels, 8-bit mismatch counter so
// saturation is reachable quickly); timeout scenario built with L1A_CHK_TIMEOUT_EN.
module tb_l1a_align_checker_n;
  import l1a_chk_pkg::*;

  localparam int               N_CH    = 4;
  localparam int               L1A_W   = 14;
  localparam int               TMO_W   = 16;
  localparam logic [TMO_W-1:0] TMO_CYC = 16'd10;
  localparam int               CNT_W   = 8;

  logic                  clk = 1'b0;
  logic                  reset, check_en, clr_err;
  logic [N_CH-1:0]       ch_en, trig_in;
  logic [N_CH*L1A_W-1:0] l1a_in;
  logic                  l1a_align, round_done, ch_done, busy;
  logic [N_CH-1:0]       error, err_sticky;
  logic [L1A_W-1:0]      ref_l1a;
  logic [CNT_W-1:0]      mismatch_cnt;
  l1a_chk_state_e        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  l1a_align_checker_n #(
    .N_CH(N_CH), .L1A_W(L1A_W), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .check_en(check_en), .ch_en(ch_en), .trig_in(trig_in),
    .l1a_in(l1a_in), .clr_err(clr_err), .l1a_align(l1a_align), .round_done(round_done),
    .ch_done(ch_done), .error(error), .err_sticky(err_sticky), .ref_l1a(ref_l1a),
    .mismatch_cnt(mismatch_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_l1a(input int k, input logic [L1A_W-1:0] v);
    l1a_in[k*L1A_W +: L1A_W] = v;
  endtask

  task automatic set_all_l1a(input logic [L1A_W-1:0] v);
    for (int k = 0; k < N_CH; k++) set_l1a(k, v);
  endtask

  task automatic strobe(input int k);
    trig_in = N_CH'(1) << k;
    tick();
    trig_in = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; check_en = 1'b0; clr_err = 1'b0; ch_en = '0; trig_in = '0; l1a_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({l1a_align, round_done, ch_done, error, err_sticky, ref_l1a, mismatch_cnt, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got err=%b sticky=%b ref=%h cnt=%h busy=%b, required all zero",
               error, err_sticky, ref_l1a, mismatch_cnt, busy);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d required IDLE", dbg_state);
    end
  endtask

  task automatic test_no_channels();
    ch_en = '0; check_en = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({busy, dbg_state} !== {1'b0, IDLE}) begin
      tests_failed++; $display("FAIL empty_mask_start: busy=%b state=%0d required 0/IDLE", busy, dbg_state);
    end
    check_en = 1'b0;
    strobe(0);
    tests_run++;
    if ({error, err_sticky} !== 8'h00) begin
      tests_failed++; $display("FAIL empty_mask_idle_trig: err=%b sticky=%b required 0/0", error, err_sticky);
    end
  endtask

  task automatic test_clean_round();
    set_all_l1a(14'h0123);
    ch_en = 4'hF; check_en = 1'b1;
    tick();
    tests_run++;
    if ({busy, dbg_state} !== {1'b1, CAPTURE_REF}) begin
      tests_failed++; $display("FAIL clean_start: busy=%b state=%0d required 1/CAPTURE_REF", busy, dbg_state);
    end
    for (int k = 0; k < N_CH; k++) begin
      strobe(k);
      tests_run++;
      if (ch_done !== 1'b1) begin
        tests_failed++; $display("FAIL clean_ch_done%0d: got %b required 1", k, ch_done);
      end
    end
    tests_run++;
    if ({round_done, ref_l1a} !== {1'b0, 14'h0123}) begin
      tests_failed++; $display("FAIL clean_ref: round_done=%b ref=%h required 0/0123", round_done, ref_l1a);
    end
    tick();
    tests_run++;
    if ({round_done, l1a_align, error, busy} !== {1'b1, 1'b1, 4'b0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL clean_done: rd=%b align=%b err=%b busy=%b required 1/1/0000/0",
               round_done, l1a_align, error, busy);
    end
    check_en = 1'b0;
    tick();
    tests_run++;
    if ({round_done, l1a_align} !== 2'b00) begin
      tests_failed++; $display("FAIL clean_pulse_width: rd=%b align=%b required 0/0", round_done, l1a_align);
    end
  endtask

  task automatic test_mismatch();
    set_all_l1a(14'h0123);
    set_l1a(2, 14'h0124);
    ch_en = 4'hF; check_en = 1'b1;
    tick();
    strobe(0); strobe(1); strobe(2);
    tests_run++;
    if ({error, err_sticky, mismatch_cnt} !== {4'b0100, 4'b0100, 8'd1}) begin
      tests_failed++;
      $display("FAIL mismatch_flags: err=%b sticky=%b cnt=%0d required 0100/0100/1", error, err_sticky, mismatch_cnt);
    end
    strobe(3);
    tests_run++;
    if (ch_done !== 1'b1) begin
      tests_failed++; $display("FAIL mismatch_no_stall: ch_done=%b required 1", ch_done);
    end
    tick();
    tests_run++;
    if ({round_done, l1a_align} !== 2'b10) begin
      tests_failed++; $display("FAIL mismatch_done: rd=%b align=%b required 1/0", round_done, l1a_align);
    end
    check_en = 1'b0;
    tick();
    set_l1a(2, 14'h0123);
    check_en = 1'b1;
    tick();
    for (int k = 0; k < N_CH; k++) strobe(k);
    tick();
    tests_run++;
    if ({round_done, l1a_align, error, err_sticky, mismatch_cnt} !== {1'b1, 1'b1, 4'b0000, 4'b0100, 8'd1}) begin
      tests_failed++;
      $display("FAIL recover_round: rd=%b align=%b err=%b sticky=%b cnt=%0d required 1/1/0000/0100/1",
               round_done, l1a_align, error, err_sticky, mismatch_cnt);
    end
    check_en = 1'b0;
    tick();
  endtask

  task automatic test_sparse_mask();
    set_l1a(0, 14'h0000); set_l1a(1, 14'h3FFF); set_l1a(2, 14'h1111); set_l1a(3, 14'h3FFF);
    ch_en = 4'b1010; check_en = 1'b1;
    tick();
    ch_en = 4'b0111;  // ignored until the next round starts
    strobe(0);
    tests_run++;
    if (ch_done !== 1'b0) begin
      tests_failed++; $display("FAIL sparse_ignore_ch0: ch_done=%b required 0", ch_done);
    end
    strobe(1);
    tests_run++;
    if ({ch_done, ref_l1a} !== {1'b1, 14'h3FFF}) begin
      tests_failed++; $display("FAIL sparse_ref: ch_done=%b ref=%h required 1/3fff", ch_done, ref_l1a);
    end
    strobe(2);
    tests_run++;
    if (ch_done !== 1'b0) begin
      tests_failed++; $display("FAIL sparse_ignore_ch2: ch_done=%b required 0", ch_done);
    end
    strobe(3);
    tick();
    tests_run++;
    if ({round_done, l1a_align, error} !== {1'b1, 1'b1, 4'b0000}) begin
      tests_failed++; $display("FAIL sparse_done: rd=%b align=%b err=%b required 1/1/0000", round_done, l1a_align, error);
    end
    check_en = 1'b0; ch_en = 4'hF;
    tick();
  endtask

  task automatic test_idle_trig_and_abort();
    set_all_l1a(14'h0123);
    check_en = 1'b0; ch_en = 4'hF;
    strobe(0);
    tests_run++;
    if ({error, err_sticky, busy, dbg_state} !== {4'b0001, 4'b0101, 1'b0, IDLE}) begin
      tests_failed++;
      $display("FAIL idle_trig: err=%b sticky=%b busy=%b state=%0d required 0001/0101/0/IDLE",
               error, err_sticky, busy, dbg_state);
    end
    check_en = 1'b1;
    tick();
    strobe(0); strobe(1);
    check_en = 1'b0;
    tick();
    tests_run++;
    if ({busy, dbg_state, round_done, error} !== {1'b0, IDLE, 1'b0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL abort_idle: busy=%b state=%0d rd=%b err=%b required 0/IDLE/0/0000",
               busy, dbg_state, round_done, error);
    end
    tick();
    tests_run++;
    if ({round_done, l1a_align} !== 2'b00) begin
      tests_failed++; $display("FAIL abort_no_pulse: rd=%b align=%b required 0/0", round_done, l1a_align);
    end
  endtask

  task automatic test_saturation_and_clear();
    set_all_l1a(14'h0001);
    set_l1a(0, 14'h0000);
    ch_en = 4'hF; trig_in = 4'hF; check_en = 1'b1;
    repeat (600) tick();
    tests_run++;
    if ({mismatch_cnt, err_sticky} !== {8'hFF, 4'hF}) begin
      tests_failed++; $display("FAIL saturate: cnt=%h sticky=%b required ff/1111", mismatch_cnt, err_sticky);
    end
    repeat (12) tick();
    trig_in = '0; check_en = 1'b0;
    tick(); tick();
    tests_run++;
    if (mismatch_cnt !== 8'hFF) begin
      tests_failed++; $display("FAIL saturate_hold: cnt=%h required ff", mismatch_cnt);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tests_run++;
    if ({err_sticky, mismatch_cnt} !== 12'h000) begin
      tests_failed++; $display("FAIL clr_err: sticky=%b cnt=%h required 0000/00", err_sticky, mismatch_cnt);
    end
    clr_err = 1'b1; trig_in = 4'b0001;
    tick();
    clr_err = 1'b0; trig_in = '0;
    tests_run++;
    if ({err_sticky, error[0], mismatch_cnt} !== {4'b0001, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL clr_vs_new_err: sticky=%b err0=%b cnt=%h required 0001/1/00", err_sticky, error[0], mismatch_cnt);
    end
  endtask

  task automatic test_reset_mid_round();
    set_all_l1a(14'h0123);
    set_l1a(2, 14'h0200);
    ch_en = 4'hF; check_en = 1'b1;
    tick();
    strobe(0); strobe(1); strobe(2);
    reset = 1'b1;
    tick();
    tests_run++;
    if ({l1a_align, round_done, ch_done, error, err_sticky, ref_l1a, mismatch_cnt, busy} !== '0
        || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid_round: err=%b sticky=%b ref=%h cnt=%h busy=%b state=%0d required all zero/IDLE",
               error, err_sticky, ref_l1a, mismatch_cnt, busy, dbg_state);
    end
    reset = 1'b0; check_en = 1'b0;
    tick();
  endtask

`ifdef L1A_CHK_TIMEOUT_EN
  task automatic test_timeout();
    set_all_l1a(14'h0123);
    ch_en = 4'hF; check_en = 1'b1;
    tick();
    strobe(0);
    repeat (9) tick();
    tests_run++;
    if ({error[1], ch_done} !== 2'b00) begin
      tests_failed++; $display("FAIL tmo_early: err1=%b ch_done=%b required 0/0", error[1], ch_done);
    end
    tick();
    tests_run++;
    if ({error[1], ch_done, mismatch_cnt} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL tmo_fire: err1=%b ch_done=%b cnt=%h required 1/1/00", error[1], ch_done, mismatch_cnt);
    end
    strobe(2); strobe(3);
    tick();
    tests_run++;
    if ({round_done, l1a_align, mismatch_cnt, ref_l1a} !== {1'b1, 1'b0, 8'h00, 14'h0123}) begin
      tests_failed++;
      $display("FAIL tmo_round: rd=%b align=%b cnt=%h ref=%h required 1/0/00/0123",
               round_done, l1a_align, mismatch_cnt, ref_l1a);
    end
    check_en = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_no_channels();
    test_clean_round();
    test_mismatch();
    test_sparse_mask();
    test_idle_trig_and_abort();
    test_saturation_and_clear();
    test_reset_mid_round();
`ifdef L1A_CHK_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
